fpr_addsub_seq: RTL and testbench
=================================

// Module: fpr_addsub_seq
// PURPOSE
//  Handshaked, multi-cycle IEEE-754 single-precision add/subtract unit. It is the responding end of the operand/result interface: an initiator issues (a, b, adsb) and receives C.
//  Arithmetic semantics match fpr_add: C = a + b when adsb=0, C = a - b when adsb=1.
//  Shift-one-bit-per-cycle datapath: small area, variable latency. Used by sequencers and by the bench scoreboard.
// PARAMETERS
//  EXP_W   8   exponent width
//  FRAC_W  23  stored fraction width (word width = 1+EXP_W+FRAC_W)
//  GRS_W   3   guard/round/sticky extension bits carried through the datapath
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  rst_n      in   1   asynchronous assert, active-low reset
//  in_valid   in   1   operand triple valid
//  in_ready   out  1   unit can accept operands (high only in IDLE)
//  a          in   32  operand A
//  b          in   32  operand B
//  adsb       in   1   0 = add, 1 = subtract
//  out_valid  out  1   C holds a result (high only in DONE)
//  out_ready  in   1   consumer accepts C
//  C          out  32  result
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, C=0. All internal registers clear.
//  Reset mid-operation aborts the operation with no output. The first edge after release is IDLE.
//  Accept: in_valid&&in_ready at an edge latches a, b, adsb. Inputs are don't-care at all other times.
//  States: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
//  UNPACK: split the operands and apply the specials (below). Specials go straight to DONE.
//    The effective sign of B is b[31]^adsb.
//    Operands are swapped so that |A| >= |B|; exponent first, then fraction.
//    d = min(expA-expB, FRAC_W+GRS_W).
//  ALIGN: d cycles. Each cycle shifts B's significand right by 1; bits shifted out OR into sticky. Skipped when d=0.
//  ADD: one cycle. Same effective sign: add magnitudes; otherwise subtract (A-B). Result sign = sign of A.
//  NORM: n cycles, where n is the normalisation count.
//    Carry-out: one right shift (sticky kept), exp+1.
//    Otherwise: shift left 1 per cycle with exp-1 until the hidden bit is set.
//    Skipped when already normal.
//  ROUND: one cycle, round-to-nearest-even on G/R/S.
//    A rounding carry re-normalises in the same cycle.
//    exp >= 255 gives +/-inf. exp <= 0 flushes to signed zero.
//  DONE: out_valid=1 and C stable until out_valid&&out_ready, then IDLE. Holds indefinitely under backpressure.
//  Latency (accept edge to out_valid rising):
//    normal operands: 4+d+n edges
//    specials: 2 edges
//    worst case: 4+26+25 = 55 edges
//  Throughput: one operation in flight. in_ready=0 from the accept edge until the DONE handshake.
//    No accept in the same cycle as out handshake; the next operand is accepted at the earliest on the following edge.
//  Specials, evaluated in priority order:
//    any NaN -> 0x7FC00000
//    inf op inf with opposite effective signs -> 0x7FC00000
//    any inf -> that inf, with effective sign applied
//    denormal inputs are treated as signed zero
//    exact-zero magnitude result -> +0 (0x00000000)
//    both zeros negative (effective) -> -0 (0x80000000)
// STRUCTURE
//  Package fpr_pkg: EXP_W/FRAC_W/BIAS constants, canonical QNAN and INF words, state enum, unpacked-float typedef (sign, exp, sig+GRS).
//  One sub-module fpr_unpack_class (combinational): word -> {sign, exp, sig, is_zero, is_inf, is_nan}. Used for a and b.
//  FSM, shifters and rounder live in this module.
// TESTING
//  a=0x443CB6A8, b=0x447D37F0, adsb=0 -> C=0x44DCF74C; out_valid 5 edges after accept (d=0, n=1).
//  a=0x431A399A, b=0x431A43D7, adsb=1 -> C=0xBD23D000; out_valid 16 edges after accept (n=12).
//  Rounding ties:
//    0x3F800000 + 0x33800000 -> 0x3F800000 (tie rounds to even, down)
//    0x3F800001 + 0x33800000 -> 0x3F800002 (tie rounds up)
//    0x3F800000 - 0x3F800000 -> 0x00000000
//  Specials:
//    0x7F800000 - 0x7F800000 -> 0x7FC00000 after 2 edges
//    0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000
//  Backpressure: out_ready held 0 for 10 cycles -> out_valid and C stable, in_ready=0; the next operand is accepted the edge after the handshake.
//  rst_n pulsed low during the NORM phase of the subtraction case -> out_valid never rises, in_ready=1; the next operation returns the correct result.

Source files
------------

// File: rtl/fpr_pkg.sv
// fpr_pkg: shared constants, state encoding and unpacked-float type for the fpr add/sub unit
package fpr_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int GRS_W = 3;
  localparam int SIG_W = 1 + FRAC_W + GRS_W;
  localparam int CNT_W = $clog2(SIG_W);
  localparam int BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] INF = 32'h7F800000;
  typedef logic signed [EXP_W+1:0] exp_t;
  localparam exp_t EMAX = exp_t'((1 << EXP_W) - 1);
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } ufloat_t;
endpackage

// File: rtl/fpr_unpack_class.sv
// fpr_unpack_class: splits a single-precision word and classifies it; denormals read as zero
module fpr_unpack_class
  import fpr_pkg::*;
(
  input  logic [31:0] w,
  output ufloat_t     u,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);
  logic [EXP_W-1:0] e;
  assign e = w[30:FRAC_W];
  assign is_zero = e == '0;
  assign is_inf = &e && w[FRAC_W-1:0] == '0;
  assign is_nan = &e && |w[FRAC_W-1:0];
  assign u = {w[31], e, 1'b1, w[FRAC_W-1:0], {GRS_W{1'b0}}};
endmodule

// File: rtl/fpr_addsub_seq.sv
// fpr_addsub_seq: handshaked multi-cycle single-precision add/subtract
// with one-bit-per-cycle alignment and normalisation shifters.
module fpr_addsub_seq
  import fpr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        adsb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] C,
  output logic        busy
);
  state_t state, nxt;
  logic [31:0] a_q, b_q, c_q;
  logic op_q, sa, same;
  exp_t e;
  logic [SIG_W-1:0] sig_a, sig_b;
  logic [SIG_W:0] acc, sum, nacc;
  logic [CNT_W-1:0] cnt, d;
  ufloat_t ua, ubr, ub, hi, lo;
  logic za, ia, na, zb, ib, nb, sb, spec;
  logic [31:0] spec_w, rnd_w;
  logic [EXP_W-1:0] diff;
  logic up;
  logic [FRAC_W+1:0] m;
  exp_t re;
  logic [FRAC_W-1:0] frac;

  fpr_unpack_class u_a (.w(a_q), .u(ua), .is_zero(za), .is_inf(ia), .is_nan(na));
  fpr_unpack_class u_b (.w(b_q), .u(ubr), .is_zero(zb), .is_inf(ib), .is_nan(nb));

  assign sb = ubr.sign ^ op_q;
  assign ub = {sb, ubr.exp, ubr.sig};
  assign hi = b_q[30:0] > a_q[30:0] ? ub : ua;
  assign lo = b_q[30:0] > a_q[30:0] ? ua : ub;
  assign diff = hi.exp - lo.exp;
  assign d = diff > EXP_W'(SIG_W - 1) ? CNT_W'(SIG_W - 1) : diff[CNT_W-1:0];
  assign spec = na | nb | ia | ib | za | zb;
  assign spec_w = na || nb ? QNAN :
                  ia && ib && ua.sign != sb ? QNAN :
                  ia ? a_q :
                  ib ? {sb, b_q[30:0]} :
                  za && zb ? {ua.sign & sb, 31'b0} :
                  za ? {sb, b_q[30:0]} : a_q;

  assign sum = same ? {1'b0, sig_a} + {1'b0, sig_b} : {1'b0, sig_a} - {1'b0, sig_b};
  // a carry shifts right once keeping sticky; otherwise walk the hidden bit up
  assign nacc = acc[SIG_W] ? {1'b0, acc[SIG_W:2], |acc[1:0]} : {acc[SIG_W-1:0], 1'b0};

  assign up = acc[2] & (acc[1] | acc[0] | acc[GRS_W]);
  assign m = {1'b0, acc[SIG_W-1:GRS_W]} + (FRAC_W+2)'(up);
  assign re = e + exp_t'(m[FRAC_W+1]);
  assign frac = m[FRAC_W+1] ? m[FRAC_W:1] : m[FRAC_W-1:0];
  assign rnd_w = acc == '0 ? 32'h0 :
                 re >= EMAX ? {sa, INF[30:0]} :
                 re <= exp_t'(0) ? {sa, 31'b0} : {sa, re[EXP_W-1:0], frac};

  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign C = c_q;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = in_valid ? UNPACK : IDLE;
      UNPACK:  nxt = spec ? DONE : d == '0 ? ADD : ALIGN;
      ALIGN:   nxt = cnt == CNT_W'(1) ? ADD : ALIGN;
      ADD:     nxt = sum == '0 || (!sum[SIG_W] && sum[SIG_W-1]) ? ROUND : NORM;
      NORM:    nxt = nacc[SIG_W-1] ? ROUND : NORM;
      ROUND:   nxt = DONE;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= 1'b0;
      c_q <= '0;
      sa <= 1'b0;
      same <= 1'b0;
      e <= '0;
      sig_a <= '0;
      sig_b <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          op_q <= adsb;
        end
        UNPACK: begin
          sa <= hi.sign;
          same <= hi.sign == lo.sign;
          e <= exp_t'({2'b00, hi.exp});
          sig_a <= hi.sig;
          sig_b <= lo.sig;
          cnt <= d;
          if (spec) c_q <= spec_w;
        end
        ALIGN: begin
          sig_b <= {1'b0, sig_b[SIG_W-1:2], |sig_b[1:0]};
          cnt <= cnt - CNT_W'(1);
        end
        ADD: acc <= sum;
        NORM: begin
          acc <= nacc;
          e <= acc[SIG_W] ? e + exp_t'(1) : e - exp_t'(1);
        end
        ROUND: c_q <= rnd_w;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpr_addsub_seq.sv
// tb_fpr_addsub_seq: directed vectors with hand-computed results and latencies
module tb_fpr_addsub_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic adsb = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic in_ready, out_valid, busy;
  logic [31:0] C;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpr_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .adsb(adsb), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic s, input string tag);
    @(negedge clk);
    a = av;
    b = bv;
    adsb = s;
    in_valid = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [31:0] ec, input int el);
    int lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_c"}, C, ec);
    if (el > 0) chk({tag, "_lat"}, 32'(lat), 32'(el));
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run(input logic [31:0] av, input logic [31:0] bv, input logic s,
                     input logic [31:0] ec, input int el, input string tag);
    issue(av, bv, s, tag);
    wait_out(tag, ec, el);
    take();
  endtask

  initial begin
    int seen;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_c", C, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(32'h443CB6A8, 32'h447D37F0, 1'b0, 32'h44DCF74C, 5, "add_carry");
    run(32'h431A399A, 32'h431A43D7, 1'b1, 32'hBD23D000, 16, "sub_cancel");
    run(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 28, "tie_even");
    run(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 28, "tie_up");
    run(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4, "exact_zero");
    run(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2, "inf_minus_inf");
    run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5, "overflow");
    run(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 2, "nan");
    run(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 2, "one_minus_inf");
    run(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 2, "neg_zeros");
    run(32'h40400000, 32'h00000001, 1'b0, 32'h40400000, 2, "denorm_b");
    run(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 29, "deep_norm");
    run(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 6, "neg_result");
    run(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 30, "align_cap");
    // backpressure, then a new operand offered together with the handshake
    issue(32'h443CB6A8, 32'h447D37F0, 1'b0, "bp");
    wait_out("bp", 32'h44DCF74C, 5);
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_c", C, 32'h44DCF74C);
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    a = 32'h431A399A;
    b = 32'h431A43D7;
    adsb = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_next_busy", 32'(busy), 32'd1);
    wait_out("bp_next", 32'hBD23D000, 16);
    take();
    // reset during normalisation of the subtraction
    issue(32'h431A399A, 32'h431A43D7, 1'b1, "rst_mid");
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rdy", 32'(in_ready), 32'd1);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1;
    end
    chk("rst_mid_no_out", 32'(seen), 32'd0);
    chk("rst_mid_idle", 32'(in_ready), 32'd1);
    run(32'h431A399A, 32'h431A43D7, 1'b1, 32'hBD23D000, 16, "after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
